conv_seq_ctrl: RTL and testbench
================================

// Module: conv_seq_ctrl
// PURPOSE
//  Sequencer for the 4-bit combinational code converter and its 7-segment display path.
//  Accepts a 4-bit code over a valid/ready handshake and drives the converter inputs.
//  Asserts the converter's ready gate for a settle window, then captures the 4-bit result.
//  Presents the result downstream over valid/ready and drives a latched hex 7-seg image.
// PARAMETERS
//  SETTLE_CYC  2  cycles converter ready is held before capture (>=1)
//  CNT_W       8  width of completed-conversion counter
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous active-high reset
//  in_valid    in   1      in_code valid
//  in_code     in   4      code to convert (bit3=A .. bit0=D)
//  in_ready    out  1      controller can accept a code
//  conv_abcd   out  4      to converter A,B,C,D (bit3=A)
//  conv_ready  out  1      to converter ready gate
//  conv_s      in   4      from converter S3..S0 (bit3=S3)
//  out_valid   out  1      out_code valid
//  out_code    out  4      captured converter result
//  out_ready   in   1      downstream accepts out_code
//  err         out  1      captured result > 9 (not a decimal digit)
//  seg         out  7      active-high segments, seg[0]=a .. seg[6]=g
//  conv_count  out  CNT_W  completed output transfers, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, conv_abcd=0, conv_ready=0, out_code=0,
//    out_valid=0, err=0, seg=7'h00 (blank), conv_count=0, settle counter=0. in_ready=1 after release.
//  - FSM states: IDLE, SETTLE, CAPT, PRESENT.
//  - IDLE: in_ready=1. On in_valid&in_ready at edge: conv_abcd<=in_code, cnt<=0 -> SETTLE.
//  - SETTLE: conv_ready=1; cnt increments each cycle; after SETTLE_CYC cycles in SETTLE -> CAPT.
//  - CAPT (1 cycle): conv_ready=1; at exit edge out_code<=conv_s, err<=(conv_s>9),
//    seg<=hex image of conv_s, out_valid<=1 -> PRESENT.
//  - PRESENT: out_valid=1, out_code/err stable; on out_valid&out_ready: out_valid<=0,
//    conv_count<=conv_count+1 (wrap), -> IDLE.
//  - in_ready=0 in SETTLE, CAPT, PRESENT; in_valid ignored there (no queuing, no bypass).
//  - conv_ready=0 in IDLE and PRESENT; conv_abcd holds last accepted code until next accept.
//  - Latency: accept edge E0 -> out_valid high after edge E0+SETTLE_CYC+1.
//    Earliest next accept: cycle after the output transfer.
//  - seg latched at capture; persists through IDLE until next capture or reset.
//  - Hex image (gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//    8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//  - conv_s sampled only at CAPT exit edge; changes at other times have no effect.
//  - out_ready held high before PRESENT has no effect; transfer needs out_valid=1.
//  - Reset asserted mid-SETTLE/CAPT/PRESENT aborts; in-flight result discarded, no count.
//  - conv_count 2^CNT_W-1 -> 0 on next transfer; no flag.
// TESTING
//  Bench converter model: conv_s = conv_abcd+3 (mod 16) when conv_ready=1, else 0.
//  1. Reset pulse mid-run -> all outputs at reset values, seg=00, in_ready=1 next cycle.
//  2. SETTLE_CYC=2, in_code=5 accepted at E0 -> conv_ready high E0..E0+3,
//     out_valid rises after E0+3, out_code=8, err=0, seg=7F; out_ready=1 -> conv_count=1, IDLE.
//  3. in_code=9 -> out_code=C, err=1, seg=39; in_code=D -> out_code=0, err=0, seg=3F.
//  4. out_ready=0 for 10 cycles in PRESENT -> out_valid/out_code/seg stable, in_ready=0,
//     in_valid pulses ignored; out_ready=1 -> single transfer, count +1.
//  5. Reset asserted in SETTLE after accepting 7 -> immediate IDLE, out_valid never rises,
//     conv_count unchanged (0), conv_abcd=0.
//  6. CNT_W=2, 5 back-to-back conversions with out_ready=1 -> conv_count 1,2,3,0,1.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a 4-bit combinational code converter and its 7-segment display path.
// Accepts a code, gates the converter for a settle window, captures and presents the result.
module conv_seq_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_code,
  output logic             in_ready,
  output logic [3:0]       conv_abcd,
  output logic             conv_ready,
  input  logic [3:0]       conv_s,
  output logic             out_valid,
  output logic [3:0]       out_code,
  input  logic             out_ready,
  output logic             err,
  output logic [6:0]       seg,
  output logic [CNT_W-1:0] conv_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the payload is stable while valid is high.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPT    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam int CNT_SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_SW-1:0] SETTLE_LAST = CNT_SW'(SETTLE_CYC - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_SW-1:0] r_cnt;
  logic [3:0]        r_abcd;
  logic [3:0]        r_out_code;
  logic              r_err;
  logic [6:0]        r_seg;
  logic [CNT_W-1:0]  r_count;

  logic w_in_ready;
  logic w_conv_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_xfer;
  logic w_settle_done;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_accept      = in_valid & w_in_ready;
  assign w_xfer        = w_out_valid & out_ready;
  assign w_settle_done = (r_state == SETTLE) && (r_cnt == SETTLE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SETTLE;
      SETTLE:  if (w_settle_done) w_next = CAPT;
      CAPT:    w_next = PRESENT;
      PRESENT: if (w_xfer) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready   = 1'b0;
    w_conv_ready = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE:    w_in_ready   = 1'b1;
      SETTLE:  w_conv_ready = 1'b1;
      CAPT:    w_conv_ready = 1'b1;
      PRESENT: w_out_valid  = 1'b1;
      default: w_in_ready   = 1'b0;
    endcase
  end

  // The converter result is sampled only on the edge that leaves CAPT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_abcd     <= 4'h0;
      r_out_code <= 4'h0;
      r_err      <= 1'b0;
      r_seg      <= 7'h00;
      r_count    <= '0;
    end else begin
      if (w_accept) begin
        r_abcd <= in_code;
        r_cnt  <= '0;
      end else if ((r_state == SETTLE) && !w_settle_done) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == CAPT) begin
        r_out_code <= conv_s;
        r_err      <= (conv_s > 4'd9);
        r_seg      <= hex7(conv_s);
      end
      if (w_xfer) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign conv_abcd  = r_abcd;
  assign conv_ready = w_conv_ready;
  assign out_valid  = w_out_valid;
  assign out_code   = r_out_code;
  assign err        = r_err;
  assign seg        = r_seg;
  assign conv_count = r_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: directed codes, +3 converter model, queue scoreboard
// checked by an independent output monitor.
module tb_conv_seq_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [3:0]       in_code = 4'h0;
  logic             in_ready;
  logic [3:0]       conv_abcd;
  logic             conv_ready;
  logic [3:0]       conv_s;
  logic             out_valid;
  logic [3:0]       out_code;
  logic             out_ready = 1'b0;
  logic             err;
  logic [6:0]       seg;
  logic [CNT_W-1:0] conv_count;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [11:0]      exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  conv_seq_ctrl #(.SETTLE_CYC(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .conv_abcd(conv_abcd), .conv_ready(conv_ready),
    .conv_s(conv_s), .out_valid(out_valid), .out_code(out_code),
    .out_ready(out_ready), .err(err), .seg(seg), .conv_count(conv_count),
    .dbg_state(dbg_state)
  );

  // Converter model: A..D plus three, only while gated.
  assign conv_s = conv_ready ? (conv_abcd + 4'd3) : 4'd0;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output transfer.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_code", out_code, e[11:8]);
          check("err", err, e[7]);
          check("seg", seg, e[6:0]);
          check("count_pre_xfer", conv_count, exp_cnt);
          exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_conv_abcd", conv_abcd, 0);
    check("rst_conv_ready", conv_ready, 0);
    check("rst_out_code", out_code, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_seg", seg, 7'h00);
    check("rst_conv_count", conv_count, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  // (or after the first cycle of PRESENT when timing is checked).
  task automatic send(input logic [3:0] code, input logic [3:0] e_code,
                      input logic e_err, input logic [6:0] e_seg, input bit chk_timing);
    wait_in_ready();
    in_valid = 1'b1;
    in_code  = code;
    exp_q.push_back({e_code, e_err, e_seg});
    @(negedge clk);
    in_valid = 1'b0;
    if (chk_timing) begin
      for (int k = 0; k < 3; k++) begin
        check("settle_conv_ready", conv_ready, 1);
        check("settle_out_valid", out_valid, 0);
        check("settle_in_ready", in_ready, 0);
        check("settle_conv_abcd", conv_abcd, code);
        @(negedge clk);
      end
      check("present_out_valid", out_valid, 1);
      check("present_conv_ready", conv_ready, 0);
    end
  endtask

  logic [6:0]       t6_seg [5];
  logic [CNT_W-1:0] t6_cnt [5];

  initial begin
    t6_seg = '{7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
    t6_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    @(negedge clk);
    do_reset();

    // Code 5 -> 8, full latency check, single transfer.
    out_ready = 1'b1;
    send(4'h5, 4'h8, 1'b0, 7'h7F, 1'b1);
    wait_in_ready();
    check("t2_count", conv_count, 1);

    // Non-digit result and wrap of the +3 model.
    send(4'h9, 4'hC, 1'b1, 7'h39, 1'b0);
    wait_in_ready();
    check("t3a_count", conv_count, 2);
    send(4'hD, 4'h0, 1'b0, 7'h3F, 1'b0);
    wait_in_ready();
    check("t3b_count", conv_count, 3);

    // Downstream stall: output stable, in_valid pulses ignored.
    out_ready = 1'b0;
    send(4'h6, 4'h9, 1'b0, 7'h6F, 1'b0);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_out_code", out_code, 4'h9);
      check("stall_seg", seg, 7'h6F);
      check("stall_in_ready", in_ready, 0);
      check("stall_conv_abcd", conv_abcd, 4'h6);
      in_valid = i[0];
      in_code  = 4'h3;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_count_wrap", conv_count, 0);
    check("stall_out_valid_drop", out_valid, 0);
    check("stall_seg_held", seg, 7'h6F);
    repeat (3) @(negedge clk);
    check("stall_no_extra", out_valid, 0);

    // Reset while a result is presented.
    out_ready = 1'b0;
    send(4'hB, 4'hE, 1'b1, 7'h79, 1'b0);
    wait_out_valid();
    check("t1_err_before", err, 1);
    do_reset();
    out_ready = 1'b1;

    // Reset in SETTLE after accepting 7.
    send(4'h7, 4'hA, 1'b1, 7'h77, 1'b0);
    check("t5_in_settle", dbg_state, 1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      check("t5_no_out_valid", out_valid, 0);
      @(negedge clk);
    end
    check("t5_count", conv_count, 0);
    check("t5_conv_abcd", conv_abcd, 0);

    // Back-to-back conversions through the counter wrap.
    for (int i = 0; i < 5; i++) begin
      logic [3:0] c;
      c = 4'(i);
      send(c, c + 4'd3, 1'b0, t6_seg[i], 1'b0);
      wait_in_ready();
      check("t6_count", conv_count, t6_cnt[i]);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
